test_result_ctrl: RTL and testbench

//  Collects the CPU self-test handshake (test_step/test_good/test_ended) and sequences the board LEDs.

---
 rtl/test_result_ctrl_pkg.sv | 24 ++
 rtl/test_result_ctrl_if.sv | 21 ++
 rtl/test_result_ctrl_cnt_down.sv | 29 ++
 rtl/test_result_ctrl.sv | 157 +++++++++++++++
 tb/tb_test_result_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/test_result_ctrl_pkg.sv
// Self-test result controller: shared state encoding
// and default LED/watchdog timing constants.
package eco32_test_pkg;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_PASS     = 3'd1,
      ST_FAIL_ON  = 3'd2,
      ST_FAIL_OFF = 3'd3,
      ST_FAIL_GAP = 3'd4,
      ST_TMO      = 3'd5
   } state_t;

   localparam int DEF_STEP_W    = 4;
   localparam int DEF_BLINK_ON  = 5_000_000;
   localparam int DEF_BLINK_OFF = 5_000_000;
   localparam int DEF_GAP       = 20_000_000;
   localparam int DEF_TIMEOUT   = 100_000_000;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/test_result_ctrl_if.sv
// CPU self-test handshake: step pulse, pass qualifier
// and end-of-program pulse.
interface test_result_ctrl_if;

   logic test_step;
   logic test_good;
   logic test_ended;

   modport master (
      output test_step,
      output test_good,
      output test_ended
   );

   modport slave (
      input test_step,
      input test_good,
      input test_ended
   );

endinterface

// File: rtl/test_result_ctrl_cnt_down.sv
// Loadable down-counter with zero flag; shared by the
// watchdog and the LED blink phases.
module cnt_down #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] ld_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // load wins over decrement; holds at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= RST_VAL;
      else if (load)
         cnt <= ld_val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/test_result_ctrl.sv
// Self-test result controller: counts steps, latches the first
// failure, runs a watchdog and sequences the board LEDs.
module test_result_ctrl
   import eco32_test_pkg::*;
#(
   parameter int STEP_W    = DEF_STEP_W,
   parameter int BLINK_ON  = DEF_BLINK_ON,
   parameter int BLINK_OFF = DEF_BLINK_OFF,
   parameter int GAP       = DEF_GAP,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   test_result_ctrl_if.slave  bus,
   output logic [STEP_W-1:0]  step_count,
   output logic [STEP_W-1:0]  first_fail,
   output logic               fail_seen,
   output logic               done,
   output logic               timeout,
   output logic               led_g,
   output logic               led_r
);

   localparam int CMAX = max2(max2(BLINK_ON, BLINK_OFF),
                              max2(GAP, TIMEOUT));
   localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] LD_TMO = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] LD_ON  = CW'(BLINK_ON - 1);
   localparam logic [CW-1:0] LD_OFF = CW'(BLINK_OFF - 1);
   localparam logic [CW-1:0] LD_GAP = CW'(GAP - 1);

   state_t            state, state_n;
   logic [STEP_W-1:0] rem, rem_n;
   logic [STEP_W-1:0] sc_n, ff_n, sc_inc;
   logic              fs_n;
   logic              ld, en, cnt_zero;
   logic [CW-1:0]     ld_val;

   assign sc_inc = (&step_count) ? step_count
                                 : step_count + 1'b1;

   cnt_down #(
      .W       (CW),
      .RST_VAL (LD_TMO)
   ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ld),
      .en     (en),
      .ld_val (ld_val),
      .zero   (cnt_zero)
   );

   // state, step/fail bookkeeping and registered LED outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         step_count <= '0;
         first_fail <= '0;
         fail_seen  <= 1'b0;
         rem        <= '0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         led_g      <= 1'b0;
         led_r      <= 1'b0;
      end else begin
         state      <= state_n;
         step_count <= sc_n;
         first_fail <= ff_n;
         fail_seen  <= fs_n;
         rem        <= rem_n;
         done       <= (state_n != ST_RUN);
         timeout    <= (state_n == ST_TMO);
         led_g      <= (state_n == ST_PASS) ||
                       (state_n == ST_TMO);
         led_r      <= (state_n == ST_FAIL_ON) ||
                       (state_n == ST_TMO);
      end
   end

   // next state, counter control; a step in the ending
   // cycle is counted before the pass/fail decision
   always_comb begin
      state_n = state;
      sc_n    = step_count;
      ff_n    = first_fail;
      fs_n    = fail_seen;
      rem_n   = rem;
      ld      = 1'b0;
      en      = 1'b0;
      ld_val  = LD_TMO;
      unique case (state)
         ST_RUN: begin
            if (bus.test_step) begin
               sc_n = sc_inc;
               if (!bus.test_good && !fail_seen) begin
                  fs_n = 1'b1;
                  ff_n = sc_inc;
               end
            end
            if (bus.test_ended) begin
               ld = 1'b1;
               if (fs_n) begin
                  state_n = ST_FAIL_ON;
                  rem_n   = ff_n;
                  ld_val  = LD_ON;
               end else begin
                  state_n = ST_PASS;
               end
            end else if (bus.test_step) begin
               ld = 1'b1;
            end else if (cnt_zero) begin
               state_n = ST_TMO;
            end else begin
               en = 1'b1;
            end
         end
         ST_FAIL_ON: begin
            if (cnt_zero) begin
               ld    = 1'b1;
               rem_n = rem - 1'b1;
               if (rem == STEP_W'(1)) begin
                  state_n = ST_FAIL_GAP;
                  ld_val  = LD_GAP;
               end else begin
                  state_n = ST_FAIL_OFF;
                  ld_val  = LD_OFF;
               end
            end else begin
               en = 1'b1;
            end
         end
         ST_FAIL_OFF: begin
            if (cnt_zero) begin
               state_n = ST_FAIL_ON;
               ld      = 1'b1;
               ld_val  = LD_ON;
            end else begin
               en = 1'b1;
            end
         end
         ST_FAIL_GAP: begin
            if (cnt_zero) begin
               state_n = ST_FAIL_ON;
               rem_n   = first_fail;
               ld      = 1'b1;
               ld_val  = LD_ON;
            end else begin
               en = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_test_result_ctrl.sv
// Bench for test_result_ctrl: scoreboarded step/LED
// expectations over pass, fail, timeout and reset cases.
module tb_test_result_ctrl;

   localparam int STEP_W    = 4;
   localparam int BLINK_ON  = 4;
   localparam int BLINK_OFF = 4;
   localparam int GAP       = 8;
   localparam int TIMEOUT   = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [STEP_W-1:0] step_count, first_fail;
   logic              fail_seen, done, timeout, led_g, led_r;

   int checks = 0;
   int errors = 0;

   int model_sc;
   int model_ff;

   test_result_ctrl_if bus ();

   test_result_ctrl #(
      .STEP_W    (STEP_W),
      .BLINK_ON  (BLINK_ON),
      .BLINK_OFF (BLINK_OFF),
      .GAP       (GAP),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .step_count (step_count),
      .first_fail (first_fail),
      .fail_seen  (fail_seen),
      .done       (done),
      .timeout    (timeout),
      .led_g      (led_g),
      .led_r      (led_r)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.test_step  = 1'b0;
      bus.test_good  = 1'b0;
      bus.test_ended = 1'b0;
      model_sc = 0;
      model_ff = 0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic drive(input bit stp, input bit good, input bit ended);
      bus.test_step  = stp;
      bus.test_good  = good;
      bus.test_ended = ended;
      if (stp) begin
         if (model_sc < 15) model_sc++;
         if (!good && model_ff == 0) model_ff = model_sc;
      end
      tick();
      bus.test_step  = 1'b0;
      bus.test_good  = 1'b0;
      bus.test_ended = 1'b0;
   endtask

   task automatic check_steps(input string tag);
      checks++;
      if (step_count !== STEP_W'(model_sc)) begin
         errors++;
         $display("FAIL %s step_count: got %0d expected %0d", tag, step_count, model_sc);
      end
      checks++;
      if (first_fail !== STEP_W'(model_ff)) begin
         errors++;
         $display("FAIL %s first_fail: got %0d expected %0d", tag, first_fail, model_ff);
      end
      checks++;
      if (fail_seen !== (model_ff != 0)) begin
         errors++;
         $display("FAIL %s fail_seen: got %b expected %b", tag, fail_seen, model_ff != 0);
      end
   endtask

   task automatic check_blinks(input int n, input int periods, input string tag);
      logic exp_q[$];
      logic e;
      for (int p = 0; p < periods; p++) begin
         for (int k = 1; k <= n; k++) begin
            repeat (BLINK_ON) exp_q.push_back(1'b1);
            if (k < n) repeat (BLINK_OFF) exp_q.push_back(1'b0);
         end
         repeat (GAP) exp_q.push_back(1'b0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (led_r !== e || led_g !== 1'b0 || done !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s blink: got r=%b g=%b d=%b t=%b expected r=%b g=0 d=1 t=0",
                     tag, led_r, led_g, done, timeout, e);
         end
         tick();
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] exp);
      checks++;
      if ({done, timeout, led_g, led_r} !== exp) begin
         errors++;
         $display("FAIL %s dtgr: got %b expected %b", tag, {done, timeout, led_g, led_r}, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_outs("reset", 4'b0000);
      check_steps("reset");
   endtask

   task automatic test_pass();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         check_outs("pass_run", 4'b0000);
      end
      check_steps("pass_steps");
      drive(1'b0, 1'b0, 1'b1);
      check_outs("pass_end", 4'b1010);
      bus.test_step  = 1'b1;
      bus.test_good  = 1'b0;
      bus.test_ended = 1'b1;
      tick();
      bus.test_step  = 1'b0;
      bus.test_ended = 1'b0;
      repeat (40) tick();
      check_steps("pass_hold");
      check_outs("pass_hold", 4'b1010);
   endtask

   task automatic test_fail_blink();
      logic good_seq[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      foreach (good_seq[i]) drive(1'b1, good_seq[i], 1'b0);
      check_steps("fail3_steps");
      drive(1'b0, 1'b0, 1'b1);
      check_blinks(3, 2, "fail3");
   endtask

   task automatic test_timeout();
      do_reset();
      repeat (TIMEOUT - 1) tick();
      check_outs("tmo_early", 4'b0000);
      tick();
      check_outs("tmo", 4'b1111);
      drive(1'b0, 1'b0, 1'b1);
      repeat (3) tick();
      check_outs("tmo_hold", 4'b1111);
   endtask

   task automatic test_same_cycle();
      do_reset();
      drive(1'b1, 1'b0, 1'b1);
      check_steps("same_cycle");
      check_blinks(1, 2, "fail1");
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 1; i <= 20; i++) drive(1'b1, (i != 17), 1'b0);
      check_steps("sat_steps");
      drive(1'b0, 1'b0, 1'b1);
      check_blinks(15, 1, "fail15");
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1'b1, 1'b0, 1'b1);
      tick();
      check_outs("ar_pre", 4'b1001);
      #2;
      rst_n = 1'b0;
      #1;
      model_sc = 0;
      model_ff = 0;
      check_outs("ar_async", 4'b0000);
      check_steps("ar_async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (TIMEOUT - 1) tick();
      check_outs("ar_wdog_early", 4'b0000);
      tick();
      check_outs("ar_wdog", 4'b1111);
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail_blink();
      test_timeout();
      test_same_cycle();
      test_saturate();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
